lcd_controller: RTL and testbench

Bus-side model of the SED1565-style LCD controller that the PRC frame-copy engine and the CPU drive through registers 0x20FE (command/status) and 0x20FF (data). It decodes the command stream and stores data bytes into a 9-page × 132-column display RAM with auto-incrementing column address. It serves CPU reads through a one-deep read buffer (dummy-read semantics). A second, independent port lets the video output stage fetch individual pixels with display-mode transforms applied.

---
 rtl/lcd_controller.sv | 188 ++++++++++++++++++
 tb/tb_lcd_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
// Bus-side model of an SED1565-style LCD controller: command decoder, 9x132 display RAM,
// dummy-read data buffer and a pixel scan port with reverse/all-on/ADC/start-line transforms.
module lcd_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [5:0]  scan_y,
    input  logic [6:0]  scan_x,
    output logic        scan_pixel,
    output logic [5:0]  contrast,
    output logic        display_on
);

    typedef enum logic {
        CMD_IDLE     = 1'b0,
        CMD_CONTRAST = 1'b1
    } cmd_state_t;

    localparam logic [23:0] ADDR_CMD  = 24'h0020FE;
    localparam logic [23:0] ADDR_DATA = 24'h0020FF;
    localparam int          RAM_DEPTH = 1188;

    function automatic logic addr_ok(input logic [3:0] p, input logic [7:0] c);
        return (p <= 4'd8) && (c <= 8'd131);
    endfunction

    function automatic logic [10:0] ram_index(input logic [3:0] p, input logic [7:0] c);
        return 11'(p) * 11'd132 + 11'(c);
    endfunction

    logic [7:0]  ram [0:RAM_DEPTH-1];

    logic [7:0]  col_r;
    logic [7:0]  rmw_col_r;
    logic [7:0]  read_buf_r;
    logic [7:0]  a_data_r;
    logic [3:0]  page_r;
    logic [5:0]  start_line_r;
    logic [5:0]  contrast_r;
    logic        adc_r;
    logic        reverse_r;
    logic        all_on_r;
    logic        display_on_r;
    logic        rmw_r;
    logic        reload_r;
    logic        load_pend_r;
    logic        a_valid_r;
    cmd_state_t  cmd_state_r;

    logic        cmd_wr_s;
    logic        data_wr_s;
    logic        data_rd_s;
    logic        soft_rst_s;
    logic        a_ok_s;
    logic [10:0] a_idx_s;
    logic [5:0]  scan_row_s;
    logic [7:0]  scan_col_s;
    logic [10:0] scan_idx_s;
    logic [7:0]  scan_byte_s;
    logic        scan_bit_s;

    assign contrast   = contrast_r;
    assign display_on = display_on_r;

    // A simultaneous write wins; the read then has no side effect.
    assign cmd_wr_s   = bus_write && (bus_address_in == ADDR_CMD);
    assign data_wr_s  = bus_write && (bus_address_in == ADDR_DATA);
    assign data_rd_s  = bus_read && !bus_write && (bus_address_in == ADDR_DATA);
    assign soft_rst_s = cmd_wr_s && (cmd_state_r == CMD_IDLE) && (bus_data_in == 8'hE2);

    assign a_ok_s  = addr_ok(page_r, col_r);
    assign a_idx_s = a_ok_s ? ram_index(page_r, col_r) : 11'd0;

    assign scan_row_s  = scan_y + start_line_r;
    assign scan_col_s  = adc_r ? (8'd131 - {1'b0, scan_x}) : {1'b0, scan_x};
    assign scan_idx_s  = ram_index({1'b0, scan_row_s[5:3]}, scan_col_s);
    assign scan_byte_s = ram[scan_idx_s];
    assign scan_bit_s  = scan_byte_s[scan_row_s[2:0]];

    // Bus read mux: status, read buffer or zero.
    always_comb begin
        bus_data_out = 8'h00;
        case (bus_address_in)
            ADDR_CMD:  bus_data_out = {1'b0, adc_r, ~display_on_r, 5'b00000};
            ADDR_DATA: bus_data_out = read_buf_r;
            default:   bus_data_out = 8'h00;
        endcase
    end

    // Display RAM port A write.
    always_ff @(posedge clk) begin
        if (reset && data_wr_s && a_ok_s) begin
            ram[a_idx_s] <= bus_data_in;
        end
    end

    // Command decoder, address counters and the two-stage read-buffer reload.
    always_ff @(posedge clk) begin
        if (!reset || soft_rst_s) begin
            col_r        <= 8'd0;
            rmw_col_r    <= 8'd0;
            page_r       <= 4'd0;
            start_line_r <= 6'd0;
            adc_r        <= 1'b0;
            reverse_r    <= 1'b0;
            all_on_r     <= 1'b0;
            display_on_r <= 1'b0;
            rmw_r        <= 1'b0;
            contrast_r   <= 6'h20;
            cmd_state_r  <= CMD_IDLE;
            read_buf_r   <= 8'h00;
            a_data_r     <= 8'h00;
            a_valid_r    <= 1'b0;
            load_pend_r  <= 1'b0;
            reload_r     <= 1'b0;
        end else begin
            reload_r    <= 1'b0;
            load_pend_r <= reload_r;
            a_valid_r   <= a_ok_s;
            a_data_r    <= ram[a_idx_s];
            if (load_pend_r) begin
                read_buf_r <= a_valid_r ? a_data_r : 8'h00;
            end

            if (cmd_wr_s) begin
                if (cmd_state_r == CMD_CONTRAST) begin
                    contrast_r  <= bus_data_in[5:0];
                    cmd_state_r <= CMD_IDLE;
                end else begin
                    casez (bus_data_in)
                        8'b0000_????: begin
                            col_r    <= {col_r[7:4], bus_data_in[3:0]};
                            reload_r <= 1'b1;
                        end
                        8'b0001_????: begin
                            col_r    <= {bus_data_in[3:0], col_r[3:0]};
                            reload_r <= 1'b1;
                        end
                        8'b01??_????: start_line_r <= bus_data_in[5:0];
                        8'h81:        cmd_state_r  <= CMD_CONTRAST;
                        8'hA0, 8'hA1: adc_r        <= bus_data_in[0];
                        8'hA4, 8'hA5: all_on_r     <= bus_data_in[0];
                        8'hA6, 8'hA7: reverse_r    <= bus_data_in[0];
                        8'hAE, 8'hAF: display_on_r <= bus_data_in[0];
                        8'b1011_????: begin
                            page_r   <= bus_data_in[3:0];
                            reload_r <= 1'b1;
                        end
                        8'hE0: begin
                            rmw_r     <= 1'b1;
                            rmw_col_r <= col_r;
                        end
                        8'hEE: begin
                            rmw_r    <= 1'b0;
                            col_r    <= rmw_col_r;
                            reload_r <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (data_wr_s) begin
                if (a_ok_s) begin
                    col_r <= col_r + 8'd1;
                end
                reload_r <= 1'b1;
            end else if (data_rd_s) begin
                if (!rmw_r && (col_r <= 8'd131)) begin
                    col_r <= col_r + 8'd1;
                end
                reload_r <= 1'b1;
            end
        end
    end

    // Port B: pixel fetch with display-mode transforms, one cycle latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_pixel <= 1'b0;
        end else begin
            scan_pixel <= display_on_r && (all_on_r || (scan_bit_s ^ reverse_r));
        end
    end

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: expected values queued with each stimulus,
// popped and compared when the read data or scan pixel becomes observable.
module tb_lcd_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [5:0]  scan_y;
    logic [6:0]  scan_x;
    logic        scan_pixel;
    logic [5:0]  contrast;
    logic        display_on;

    int          checks = 0;
    int          passes = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_v;
    logic [7:0]  exp_v;

    localparam logic [23:0] A_CMD  = 24'h0020FE;
    localparam logic [23:0] A_DATA = 24'h0020FF;

    lcd_controller dut (
        .clk            (clk),
        .reset          (reset),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .scan_y         (scan_y),
        .scan_x         (scan_x),
        .scan_pixel     (scan_pixel),
        .contrast       (contrast),
        .display_on     (display_on)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, simulation stopped");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [7:0] d);
        bus_write = 1'b1; bus_address_in = A_CMD; bus_data_in = d;
        @(posedge clk); #1;
        bus_write = 1'b0; bus_address_in = 24'h0; bus_data_in = 8'h00;
    endtask

    task automatic dat(input logic [7:0] d);
        bus_write = 1'b1; bus_address_in = A_DATA; bus_data_in = d;
        @(posedge clk); #1;
        bus_write = 1'b0; bus_address_in = 24'h0; bus_data_in = 8'h00;
        idle(2);
    endtask

    task automatic rd(input logic [23:0] a, output logic [7:0] v);
        bus_read = 1'b1; bus_address_in = a;
        #3 v = bus_data_out;
        @(posedge clk); #1;
        bus_read = 1'b0; bus_address_in = 24'h0;
        idle(2);
    endtask

    task automatic scan(input logic [5:0] y, input logic [6:0] x, output logic [7:0] v);
        scan_y = y; scan_x = x;
        @(posedge clk); #1;
        v = {7'b0, scan_pixel};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        exp_q.push_back(8'h00); got_v = {7'b0, scan_pixel};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL reset_scan_pixel got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h20); rd(A_CMD, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL reset_status got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL reset_read_buf got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); rd(24'h001234, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL undecoded_read got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h20); got_v = {2'b0, contrast};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL reset_contrast got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); got_v = {7'b0, display_on};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL reset_display_on got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    task automatic test_data_rw();
        cmd(8'h10); cmd(8'h00); cmd(8'hB3);
        dat(8'hAA); dat(8'h55);
        cmd(8'h00); cmd(8'hB3); idle(3);
        exp_q.push_back(8'hAA); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rd_p3_c0 got=%h exp=%h", got_v, exp_v); else passes++;
        // Read right after an address set still sees the old buffer (0x55 from col 1).
        cmd(8'h00);
        exp_q.push_back(8'h55); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL dummy_read_stale got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h55); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rd_after_dummy got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    task automatic test_scan_modes();
        logic [5:0] ys [3];
        logic [6:0] xs [3];
        ys = '{6'd0, 6'd63, 6'd20};
        xs = '{7'd5, 7'd95, 7'd40};
        cmd(8'h10); cmd(8'h05); cmd(8'hB0); dat(8'h01);
        cmd(8'hAF); cmd(8'hA7);
        exp_q.push_back(8'h00); scan(6'd0, 7'd5, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL scan_reverse got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hA6);
        exp_q.push_back(8'h01); scan(6'd0, 7'd5, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL scan_normal got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); scan(6'd1, 7'd5, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL scan_bit1 got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hA5);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h01); scan(ys[i], xs[i], got_v);
            exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL scan_all_on[%0d] got=%h exp=%h", i, got_v, exp_v); else passes++;
        end
        cmd(8'hAE);
        exp_q.push_back(8'h00); scan(6'd0, 7'd5, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL scan_display_off got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hA4);
    endtask

    task automatic test_contrast();
        cmd(8'h81); cmd(8'hAF);
        exp_q.push_back(8'h2F); got_v = {2'b0, contrast};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL contrast_set got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); got_v = {7'b0, display_on};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL contrast_no_decode got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hAF);
        exp_q.push_back(8'h01); got_v = {7'b0, display_on};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL display_on_set got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); rd(A_CMD, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL status_on got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    task automatic test_col_saturation();
        cmd(8'hB2); cmd(8'h10); cmd(8'h00); dat(8'h5A);
        cmd(8'hB1); cmd(8'h18); cmd(8'h03);
        dat(8'h11); dat(8'h22); dat(8'h33);
        cmd(8'h18); cmd(8'h03); idle(3);
        exp_q.push_back(8'h11); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL sat_col131 got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL sat_col132_zero got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hB2); cmd(8'h10); cmd(8'h00); idle(3);
        exp_q.push_back(8'h5A); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL sat_no_wrap got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    task automatic test_rmw();
        cmd(8'hB1); cmd(8'h10); cmd(8'h0A); dat(8'h77);
        cmd(8'h0A); cmd(8'hE0); idle(3);
        exp_q.push_back(8'h77); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rmw_read0 got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h77); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rmw_read1_col_held got=%h exp=%h", got_v, exp_v); else passes++;
        dat(8'h99); cmd(8'hEE); idle(3);
        exp_q.push_back(8'h99); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rmw_col_restored got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    task automatic test_adc_soft_reset();
        cmd(8'hB0); cmd(8'h18); cmd(8'h03); dat(8'h02);
        cmd(8'h41); cmd(8'hA1);
        exp_q.push_back(8'h01); scan(6'd0, 7'd0, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL adc_start_row1 got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); scan(6'd63, 7'd0, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL adc_row_wrap got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h01); scan(6'd7, 7'd0, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL adc_page1 got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hE2);
        exp_q.push_back(8'h20); rd(A_CMD, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL srst_status got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h20); got_v = {2'b0, contrast};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL srst_contrast got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL srst_read_buf got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hAF);
        exp_q.push_back(8'h01); scan(6'd0, 7'd5, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL srst_scan_defaults got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hB3); cmd(8'h10); cmd(8'h00); idle(3);
        exp_q.push_back(8'hAA); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL srst_ram_kept got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    task automatic test_reset_mid_command();
        cmd(8'h81);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        exp_q.push_back(8'h20); got_v = {2'b0, contrast};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rst_mid_contrast got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h00); got_v = {7'b0, display_on};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rst_mid_display got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'hAF);
        exp_q.push_back(8'h01); got_v = {7'b0, display_on};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rst_mid_idle_decode got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h20); got_v = {2'b0, contrast};
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rst_mid_contrast_kept got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    task automatic test_back_to_back();
        cmd(8'hB3); cmd(8'h10); cmd(8'h00); idle(3);
        exp_q.push_back(8'hAA);
        bus_write = 1'b1; bus_read = 1'b1; bus_address_in = A_DATA; bus_data_in = 8'hC3;
        #3 got_v = bus_data_out;
        @(posedge clk); #1;
        bus_write = 1'b0; bus_read = 1'b0; bus_address_in = 24'h0; bus_data_in = 8'h00;
        idle(2);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rw_same_cycle_old got=%h exp=%h", got_v, exp_v); else passes++;
        exp_q.push_back(8'h55); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rw_single_increment got=%h exp=%h", got_v, exp_v); else passes++;
        cmd(8'h00); idle(3);
        exp_q.push_back(8'hC3); rd(A_DATA, got_v);
        exp_v = exp_q.pop_front(); checks++; if (got_v !== exp_v) $display("FAIL rw_write_done got=%h exp=%h", got_v, exp_v); else passes++;
    endtask

    initial begin
        reset = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = 24'h0; bus_data_in = 8'h00;
        scan_y = 6'd0; scan_x = 7'd0;
        @(posedge clk); #1;
        test_reset();
        test_data_rw();
        test_scan_modes();
        test_contrast();
        test_col_saturation();
        test_rmw();
        test_adc_soft_reset();
        test_reset_mid_command();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
